note_lanes: RTL

NOTE_LANES -- requirements
Module: note_lanes

---
 rtl/note_pkg.sv | 20 ++
 rtl/note_lane.sv | 92 +++++++++
 rtl/note_lanes.sv | 129 ++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Shared types and parameter defaults for the note lane game block.
package note_pkg;

   localparam int JUDGE_W = 2;

   typedef enum logic [JUDGE_W-1:0] {
      NONE = 2'b00,
      GOOD = 2'b01,
      BAD  = 2'b10,
      MISS = 2'b11
   } judge_e;

   localparam int LANES_DEF    = 4;
   localparam int DEPTH_DEF    = 480;
   localparam int TICK_DIV_DEF = 5;
   localparam int HIT_WIN_DEF  = 8;
   localparam int HOLD_DEF     = 16;
   localparam int SCORE_W_DEF  = 16;

endpackage

// File: rtl/note_lane.sv
// One lane: note shift register, bottom-window hit search and
// judgement hold timer.
module note_lane
   import note_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int HIT_WIN = HIT_WIN_DEF,
   parameter int HOLD    = HOLD_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     step,
   input  logic                     spawn,
   input  logic                     key,
   input  logic [$clog2(DEPTH)-1:0] rd_row,
   output logic                     rd_bit,
   output logic [JUDGE_W-1:0]       judge,
   output judge_e                   ev,
   output logic                     miss
);

   localparam int RW = $clog2(DEPTH);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   logic [DEPTH-1:0] rows_q, rows_d, kept;
   judge_e           judge_q, judge_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             hit;
   logic [RW-1:0]    hit_idx;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = DEPTH - HIT_WIN; i < DEPTH; i++) begin
         if (rows_q[i]) begin
            hit     = 1'b1;
            hit_idx = RW'(i);
         end
      end

      // The hit is removed before the shift, so a caught bottom
      // note never falls out as a miss.
      kept = rows_q;
      if (key && hit) kept[hit_idx] = 1'b0;
      miss = step && kept[DEPTH-1];

      rows_d = kept;
      if (step) rows_d = {kept[DEPTH-2:0], 1'b0};
      if (spawn) rows_d[0] = 1'b1;

      ev = NONE;
      if (key) ev = hit ? GOOD : BAD;
      else if (miss) ev = MISS;

      judge_d = judge_q;
      hold_d  = hold_q;
      if (ev != NONE) begin
         judge_d = ev;
         hold_d  = HW'(HOLD - 1);
      end else if (judge_q != NONE) begin
         if (hold_q == '0) judge_d = NONE;
         else hold_d = hold_q - 1'b1;
      end

      if (clear) begin
         rows_d  = '0;
         judge_d = NONE;
         hold_d  = '0;
      end
   end

   always_comb begin
      rd_bit = 1'b0;
      if (int'(rd_row) < DEPTH) rd_bit = rows_q[rd_row];
   end

   assign judge = judge_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_q  <= '0;
         judge_q <= NONE;
         hold_q  <= '0;
      end else begin
         rows_q  <= rows_d;
         judge_q <= judge_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: rtl/note_lanes.sv
// Multi-lane note scroller: divider, spawn handshake and scoring.
// Define NOTE_LANES_COMBO_EN to build the consecutive-GOOD counter.
module note_lanes
   import note_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int HIT_WIN  = HIT_WIN_DEF,
   parameter int HOLD     = HOLD_DEF,
   parameter int SCORE_W  = SCORE_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     pause,
   input  logic                     tick,
   input  logic                     spawn_valid,
   output logic                     spawn_ready,
   input  logic [$clog2(LANES)-1:0] spawn_lane,
   input  logic [LANES-1:0]         key,
   input  logic [$clog2(LANES)-1:0] rd_lane,
   input  logic [$clog2(DEPTH)-1:0] rd_row,
   output logic                     rd_bit,
   output logic [2*LANES-1:0]       judge,
   output logic [SCORE_W-1:0]       score,
   output logic [SCORE_W-1:0]       miss_cnt,
   output logic [SCORE_W-1:0]       combo
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic [DW-1:0]      div_q, div_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] miss_q, miss_d;
   logic               step, xfer;
   logic [LANES-1:0]   lane_spawn, lane_key, lane_miss, lane_rd;
   judge_e             lane_ev [LANES];

   assign spawn_ready = rst_n && !pause && !clear;
   assign xfer        = spawn_valid && spawn_ready;
   assign step        = tick && !pause && (div_q == DIV_LAST);

   always_comb begin
      div_d = div_q;
      if (tick && !pause) div_d = step ? '0 : div_q + 1'b1;
      if (clear) div_d = '0;
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_spawn[g] = xfer && (int'(spawn_lane) == g);
      assign lane_key[g]   = key[g] && !pause;

      note_lane #(
         .DEPTH   (DEPTH),
         .HIT_WIN (HIT_WIN),
         .HOLD    (HOLD)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clear  (clear),
         .step   (step),
         .spawn  (lane_spawn[g]),
         .key    (lane_key[g]),
         .rd_row (rd_row),
         .rd_bit (lane_rd[g]),
         .judge  (judge[2*g +: 2]),
         .ev     (lane_ev[g]),
         .miss   (lane_miss[g])
      );
   end

   assign rd_bit = (int'(rd_lane) < LANES) && lane_rd[rd_lane];

   always_comb begin
      score_d = score_q;
      miss_d  = miss_q;
      for (int i = 0; i < LANES; i++) begin
         if (lane_ev[i] == GOOD && score_d != '1) score_d = score_d + 1'b1;
         if (lane_miss[i] && miss_d != '1) miss_d = miss_d + 1'b1;
      end
      if (clear) begin
         score_d = '0;
         miss_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         score_q <= '0;
         miss_q  <= '0;
      end else begin
         div_q   <= div_d;
         score_q <= score_d;
         miss_q  <= miss_d;
      end
   end

   assign score    = score_q;
   assign miss_cnt = miss_q;

`ifdef NOTE_LANES_COMBO_EN
   logic [SCORE_W-1:0] combo_q, combo_d;
   logic               brk;

   always_comb begin
      combo_d = combo_q;
      brk     = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_ev[i] == GOOD && combo_d != '1) combo_d = combo_d + 1'b1;
         if (lane_ev[i] == BAD || lane_miss[i]) brk = 1'b1;
      end
      // A break anywhere in the cycle beats any same-cycle GOODs.
      if (brk || clear) combo_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) combo_q <= '0;
      else combo_q <= combo_d;
   end

   assign combo = combo_q;
`else
   assign combo = '0;
`endif

endmodule
